// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory access controller:
//   - access-size encodings carried on req_size
//   - controller FSM state encoding
//   - lane (byte offset within a word) width
//   - is_misaligned(): alignment rule used when the misalignment trap is built in
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int LANE_W = 2;   // byte offset inside a 32-bit word
    localparam int WORD_W = 32;  // RAM word width handled by the lane aligner

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3   // reserved encoding, behaves exactly like SIZE_WORD
    } size_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        RD_WAIT = 3'd2,
        MERGE   = 3'd3,
        RESP    = 3'd4
    } state_e;

    // Half accesses need an even byte address, word accesses (including the
    // reserved size) need lane 0. Byte accesses are always aligned.
    function automatic logic is_misaligned(input size_e size, input logic [LANE_W-1:0] lane);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return lane[0];
            default:   return (lane != '0);
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane steering between a 32-bit RAM word and the
// right-aligned core data.
// Ports:
//   i_word       word read from the RAM
//   i_lane       byte offset of the access inside the word
//   i_size       access size (byte / half / word; reserved treated as word)
//   i_unsigned   loads: 1 = zero-extend, 0 = sign-extend
//   i_wdata      right-aligned store data
//   o_load_data  extracted and extended load result
//   o_store_word i_word with the addressed lane replaced by store data
// A byte lives at lane*8; a half lives at lane[1]*16 (lane[0] ignored here).
// -----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [LANE_W-1:0] i_lane,
    input  size_e             i_size,
    input  logic              i_unsigned,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load_data,
    output logic [WORD_W-1:0] o_store_word
);

    logic [4:0]        w_byte_sh;
    logic [4:0]        w_half_sh;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic              w_byte_sign;
    logic              w_half_sign;
    logic [WORD_W-1:0] w_byte_mask;
    logic [WORD_W-1:0] w_half_mask;

    assign w_byte_sh   = {i_lane, 3'b000};
    assign w_half_sh   = {i_lane[1], 4'b0000};
    assign w_byte      = 8'(i_word >> w_byte_sh);
    assign w_half      = 16'(i_word >> w_half_sh);
    assign w_byte_sign = !i_unsigned && w_byte[7];
    assign w_half_sign = !i_unsigned && w_half[15];
    assign w_byte_mask = 32'h0000_00FF << w_byte_sh;
    assign w_half_mask = 32'h0000_FFFF << w_half_sh;

    // NOTE: both outputs get a default before the case, so no path through
    // this block can leave them unassigned and infer a latch.
    always_comb begin
        o_load_data  = i_word;
        o_store_word = i_wdata;
        case (i_size)
            SIZE_BYTE: begin
                o_load_data  = {{24{w_byte_sign}}, w_byte};
                o_store_word = (i_word & ~w_byte_mask) | ({24'h0, i_wdata[7:0]} << w_byte_sh);
            end
            SIZE_HALF: begin
                o_load_data  = {{16{w_half_sign}}, w_half};
                o_store_word = (i_word & ~w_half_mask) | ({16'h0, i_wdata[15:0]} << w_half_sh);
            end
            default: begin
                o_load_data  = i_word;
                o_store_word = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
// Initiator for a simple-dual-port data RAM (synchronous write port A,
// one-cycle registered read port B). Takes byte-addressed load/store requests
// over valid/ready, performs sub-word extraction on loads and
// read-modify-write for byte/half stores, and returns exactly one response
// (load data or store ack) per request over valid/ready.
//
// Ports:
//   clk, rst_n                  clock; synchronous active-low reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                   request payload (byte address, right-aligned data)
//   rsp_valid/rsp_ready         response handshake (held until accepted)
//   rsp_rdata, rsp_err          load result (0 for stores), misalignment flag
//   ram_ena, ram_wea,
//   ram_addra, ram_dia          RAM write port A
//   ram_enb, ram_addrb, ram_dob RAM read port B (dob valid the cycle after enb)
//
// Configuration macro: DMEM_MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests skip the RAM and respond with
//               rsp_err=1, rsp_rdata=0
//   undefined - rsp_err is tied 0 and misaligned low address bits are ignored
// -----------------------------------------------------------------------------
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dia,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob
);

    state_e                r_state;
    state_e                w_next_state;

    logic                  r_we;
    size_e                 r_size;
    logic                  r_unsigned;
    logic [ADDR_WIDTH-1:0] r_word_addr;
    logic [LANE_W-1:0]     r_lane;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_accept;
    logic                  w_is_word;
    logic                  w_misalign;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [DATA_WIDTH-1:0] w_store_word;

    assign w_accept  = req_valid && req_ready;
    assign w_is_word = (r_size == SIZE_WORD) || (r_size == SIZE_RSVD);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(r_size, r_lane);
`else
    assign w_misalign = 1'b0;
`endif

    // In MERGE the aligner sees the word read in ISSUE; for a full-word store
    // it simply passes r_wdata through, so ram_dia always comes from here.
    dmem_lane_align u_lane_align (
        .i_word       (ram_dob),
        .i_lane       (r_lane),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        ram_ena      = 1'b0;
        ram_wea      = 1'b0;
        ram_enb      = 1'b0;
        ram_addra    = r_word_addr;
        ram_addrb    = r_word_addr;
        ram_dia      = w_store_word;

        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (w_misalign) begin
                    w_next_state = RESP;
                end else if (r_we && w_is_word) begin
                    ram_ena      = 1'b1;
                    ram_wea      = 1'b1;
                    w_next_state = RESP;
                end else begin
                    // Loads and sub-word stores both need the current word.
                    ram_enb      = 1'b1;
                    w_next_state = r_we ? MERGE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_next_state = RESP;
            end
            MERGE: begin
                ram_ena      = 1'b1;
                ram_wea      = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Reset masks the handshakes and RAM strobes immediately, so a write
        // that is in flight when reset arrives never reaches the RAM.
        if (!rst_n) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            ram_ena   = 1'b0;
            ram_wea   = 1'b0;
            ram_enb   = 1'b0;
        end
    end

    // Request payload is captured on accept; the response data register is
    // cleared there so stores and trapped accesses answer with zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_size      <= SIZE_BYTE;
            r_unsigned  <= 1'b0;
            r_word_addr <= '0;
            r_lane      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
        end else begin
            if (w_accept) begin
                r_we        <= req_we;
                r_size      <= size_e'(req_size);
                r_unsigned  <= req_unsigned;
                r_word_addr <= req_addr[ADDR_WIDTH+1:2];
                r_lane      <= req_addr[1:0];
                r_wdata     <= req_wdata;
                r_rdata     <= '0;
            end else if (r_state == RD_WAIT) begin
                r_rdata <= w_load_data;
            end
        end
    end

    assign rsp_rdata = r_rdata;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if ((r_state == ISSUE) && w_misalign) begin
            r_err <= 1'b1;
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
// Drives directed load/store requests into dmem_access_ctrl connected to a
// behavioural simple-dual-port RAM. Expected responses come from a
// byte-addressed shadow memory model; a negedge monitor compares every
// accepted response, response stability under back-pressure and RAM port
// usage. Honors DMEM_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW+1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_ena;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [31:0]   ram_dia;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [31:0]   ram_dob;

    dmem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_ena      (ram_ena),
        .ram_wea      (ram_wea),
        .ram_addra    (ram_addra),
        .ram_dia      (ram_dia),
        .ram_enb      (ram_enb),
        .ram_addrb    (ram_addrb),
        .ram_dob      (ram_dob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural RAM (plus a bench-only preload port) -------
    logic [31:0]   ram [0:(1<<AW)-1];
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;

    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (ram_ena && ram_wea) ram[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= ram[ram_addrb];
    end

    // ---------------- scoreboard bookkeeping ---------------------------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- byte-level shadow memory model -------------------------
    logic [7:0] sh [0:(4<<AW)-1];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [31:0] shadow_word(input int idx);
        return {sh[4*idx+3], sh[4*idx+2], sh[4*idx+1], sh[4*idx]};
    endfunction

    // Applies one request to the shadow memory and returns the response it
    // must produce plus the cycle (relative to accept) rsp_valid must rise.
    function automatic void model_txn(input logic we, input logic [1:0] size, input logic uns,
                                      input logic [11:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic err, output int lat);
        int nb;
        int a;
        int base;
        logic [31:0] v;
        nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a     = int'(addr);
        base  = a - (a % nb);
        rdata = '0;
        err   = 1'b0;
        lat   = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (base != a) begin
            err = 1'b1;
            lat = 2;
            return;
        end
`endif
        if (we) begin
            for (int i = 0; i < nb; i++) sh[base+i] = wdata[8*i +: 8];
            lat = (nb == 4) ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = sh[base+i];
            if (!uns && nb < 4 && v[8*nb-1])
                for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
            rdata = v;
        end
    endfunction

    // ---------------- per-cycle response monitor -----------------------------
    logic        prev_hold;
    logic [31:0] prev_rdata;
    logic        prev_err;
    int          enb_cnt = 0;
    exp_t        cur_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (ram_enb) enb_cnt++;
            if (ram_ena && ram_enb) check("port_same_addr", 32'(ram_addra != ram_addrb), 32'd1);
            if (rsp_valid) begin
                check("req_ready_while_busy", 32'(req_ready), 32'd0);
                if (prev_hold) begin
                    check("hold_rdata", rsp_rdata, prev_rdata);
                    check("hold_err", 32'(rsp_err), 32'(prev_err));
                end
                if (rsp_ready) begin
                    check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur_exp = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, cur_exp.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(cur_exp.err));
                    end
                end
            end
            prev_hold  = rsp_valid && !rsp_ready;
            prev_rdata = rsp_rdata;
            prev_err   = rsp_err;
        end
    end

    // ---------------- stimulus tasks -----------------------------------------
    task automatic preload(input int idx, input logic [31:0] val);
        @(posedge clk); #1;
        pl_we   = 1'b1;
        pl_addr = AW'(idx);
        pl_data = val;
        for (int i = 0; i < 4; i++) sh[4*idx+i] = val[8*i +: 8];
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          input int stall, output logic [31:0] got);
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          n;
        got = 'x;
        model_txn(we, size, uns, addr, wdata, e_rdata, e_err, e_lat);
        exp_q.push_back('{rdata: e_rdata, err: e_err});

        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        rsp_ready    = (stall == 0);

        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            void'(exp_q.pop_back());
            @(posedge clk); #1;
            req_valid = 1'b0;
            return;
        end

        @(posedge clk); #1;   // accept edge closes cycle T
        req_valid = 1'b0;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        check("rsp_latency", 32'(n), 32'(e_lat));
        if (!rsp_valid) begin
            void'(exp_q.pop_back());
            rsp_ready = 1'b1;
            return;
        end

        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1 rsp_ready = 1'b1;
            @(negedge clk);
        end
        got = rsp_rdata;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_handshake", {30'd0, rsp_valid, req_ready}, 32'd1);

        if (we) check("ram_vs_model", ram[addr[11:2]], shadow_word(int'(addr[11:2])));
    endtask

    // ---------------- directed sequence --------------------------------------
    logic [31:0] got;
    int          enb_before;

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        rsp_ready    = 1'b1;
        pl_we        = 1'b0;
        pl_addr      = '0;
        pl_data      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_ram_en", {29'd0, ram_ena, ram_wea, ram_enb}, 32'd0);

        preload(2, 32'h4000_0000);
        preload(3, 32'h1234_5678);
        preload(4, 32'h1000_0000);
        preload(5, 32'h8000_007F);
        preload(6, 32'h0000_0000);
        preload(8, 32'hCAFE_F00D);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_req_ready", 32'(req_ready), 32'd1);

        // Word load
        do_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0, 0, got);
        check("lit_ld_word_008", got, 32'h4000_0000);

        // Byte store then byte loads on every lane of that word
        do_req(1'b1, 2'd0, 1'b0, 12'h011, 32'hFFFF_FFAB, 0, got);
        check("lit_word4_after_sb", ram[4], 32'h1000_AB00);
        do_req(1'b0, 2'd0, 1'b0, 12'h011, 32'h0, 0, got);
        check("lit_lb_011", got, 32'hFFFF_FFAB);
        for (int l = 0; l < 4; l++) do_req(1'b0, 2'd0, 1'b1, 12'h010 + 12'(l), 32'h0, 0, got);

        // Half store to upper half, loads both ways, lower half intact
        do_req(1'b1, 2'd1, 1'b0, 12'h00E, 32'h5555_8001, 0, got);
        check("lit_word3_after_sh", ram[3], 32'h8001_5678);
        do_req(1'b0, 2'd1, 1'b1, 12'h00E, 32'h0, 0, got);
        check("lit_lhu_00e", got, 32'h0000_8001);
        do_req(1'b0, 2'd1, 1'b0, 12'h00E, 32'h0, 0, got);
        check("lit_lh_00e", got, 32'hFFFF_8001);
        do_req(1'b0, 2'd1, 1'b1, 12'h00C, 32'h0, 0, got);
        check("lit_lhu_00c", got, 32'h0000_5678);

        // Back-pressure: response held for 5 cycles, then back-to-back loads
        do_req(1'b0, 2'd2, 1'b0, 12'h014, 32'h0, 5, got);
        check("lit_stalled_lw_014", got, 32'h8000_007F);
        do_req(1'b0, 2'd0, 1'b0, 12'h014, 32'h0, 0, got);
        do_req(1'b0, 2'd0, 1'b0, 12'h017, 32'h0, 0, got);

        // Word store, read back with word and reserved size
        do_req(1'b1, 2'd2, 1'b0, 12'h018, 32'h0BAD_F00D, 0, got);
        do_req(1'b0, 2'd2, 1'b0, 12'h018, 32'h0, 0, got);
        do_req(1'b0, 2'd3, 1'b0, 12'h018, 32'h0, 0, got);
        do_req(1'b1, 2'd0, 1'b0, 12'h01B, 32'h0000_00C3, 2, got);
        check("lit_word6_after_sb", ram[6], 32'hC3AD_F00D);

        // Misaligned accesses
        enb_before = enb_cnt;
        do_req(1'b0, 2'd2, 1'b0, 12'h00A, 32'h0, 0, got);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lit_misaligned_lw_rdata", got, 32'h0);
        check("misaligned_no_read", 32'(enb_cnt - enb_before), 32'd0);
`else
        check("lit_misaligned_lw_rdata", got, 32'h4000_0000);
        check("misaligned_one_read", 32'(enb_cnt - enb_before), 32'd1);
`endif
        do_req(1'b0, 2'd1, 1'b1, 12'h00F, 32'h0, 0, got);
        do_req(1'b1, 2'd1, 1'b0, 12'h013, 32'h0000_BEEF, 0, got);

        // Reset while a word store to 0x020 sits in ISSUE
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd2;
        req_addr  = 12'h020;
        req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rst_case_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rst_issue_ram_ena", {30'd0, ram_ena, ram_wea}, 32'd0);
        check("rst_issue_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_issue_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_req_ready", 32'(req_ready), 32'd1);
        check("rst_release_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_release_rdata", rsp_rdata, 32'd0);
        check("lit_word8_unchanged", ram[8], 32'hCAFE_F00D);
        repeat (3) @(negedge clk);
        check("rst_no_response", 32'(rsp_valid), 32'd0);

        // Controller still works after the reset
        do_req(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, 0, got);
        check("lit_lw_020_after_rst", got, 32'hCAFE_F00D);

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
